// File: rtl/wb_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : wb_rr_arbiter_if
//  Brief    : Wishbone bundle between N masters, the round-robin arbiter
//             and the single downstream slave port.
//             slave  modport : arbiter view (masters in, slave port out)
//             master modport : environment view (drives masters and slave)
//  Revision : 1.0 - initial release
// ============================================================================
interface wb_rr_arbiter_if #(
    parameter int N      = 3,
    parameter int ADDR_W = 24,
    parameter int DATA_W = 16,
    parameter int SEL_W  = 2
);
    // Master-side bundle, master k occupies slot k of every packed vector
    logic [N-1:0]        m_cyc;
    logic [N-1:0]        m_stb;
    logic [N-1:0]        m_we;
    logic [N*ADDR_W-1:0] m_adr;
    logic [N*DATA_W-1:0] m_o_dat;
    logic [N*SEL_W-1:0]  m_sel;
    logic [N-1:0]        m_4_burst;
    logic [N-1:0]        m_8_burst;
    logic [N-1:0]        m_ack;
    logic [N-1:0]        m_err;
    logic [DATA_W-1:0]   m_i_dat;

    // Slave-side bundle towards the target decoder
    logic                s_cyc;
    logic                s_stb;
    logic                s_we;
    logic [ADDR_W-1:0]   s_adr;
    logic [DATA_W-1:0]   s_o_dat;
    logic [SEL_W-1:0]    s_sel;
    logic                s_4_burst;
    logic                s_8_burst;
    logic                s_ack;
    logic                s_err;
    logic [DATA_W-1:0]   s_i_dat;

    modport slave (
        input  m_cyc, m_stb, m_we, m_adr, m_o_dat, m_sel, m_4_burst, m_8_burst,
        input  s_ack, s_err, s_i_dat,
        output m_ack, m_err, m_i_dat,
        output s_cyc, s_stb, s_we, s_adr, s_o_dat, s_sel, s_4_burst, s_8_burst
    );

    modport master (
        output m_cyc, m_stb, m_we, m_adr, m_o_dat, m_sel, m_4_burst, m_8_burst,
        output s_ack, s_err, s_i_dat,
        input  m_ack, m_err, m_i_dat,
        input  s_cyc, s_stb, s_we, s_adr, s_o_dat, s_sel, s_4_burst, s_8_burst
    );
endinterface
`default_nettype wire

// File: rtl/wb_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : wb_rr_arbiter
//  Brief    : N-master round-robin Wishbone arbiter. The owner keeps the
//             slave port for as long as it holds cyc (bursts are never
//             preempted); one IDLE cycle separates consecutive owners.
//             Optional stall watchdog enabled by macro WB_ARB_TIMEOUT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module wb_rr_arbiter #(
    parameter int N       = 3,
    parameter int ADDR_W  = 24,
    parameter int DATA_W  = 16,
    parameter int SEL_W   = 2,
    parameter int TIMEOUT = 255
) (
    input  wire logic           i_clk,
    input  wire logic           i_rst,
    wb_rr_arbiter_if.slave      bus,
    output logic [N-1:0]        o_grant,
    output logic                o_busy
);
    localparam int c_ptr_w = $clog2(N);

    // Reject configurations outside the supported range at elaboration
    if (N < 2 || N > 8) begin : g_bad_n
        $error("wb_rr_arbiter: N must be 2..8");
    end
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("wb_rr_arbiter: TIMEOUT must be 1..255");
    end

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [c_ptr_w-1:0]   r_ptr, w_ptr_nxt;
    logic [c_ptr_w-1:0]   r_owner, w_owner_nxt;
    logic [N-1:0]         w_grant_nxt;
    logic                 w_found;
    logic [c_ptr_w-1:0]   w_pick;
    logic [c_ptr_w:0]     w_sum;
    logic [c_ptr_w-1:0]   w_idx;
    logic                 w_owner_cyc;
    logic                 w_owner_stb;
    logic                 w_timeout;

    // Round-robin search: first requester at ptr, ptr+1, ... (mod N)
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_sum   = '0;
        w_idx   = '0;
        for (int i = 0; i < N; i++) begin
            w_sum = {1'b0, r_ptr} + (c_ptr_w+1)'(i);
            w_idx = (w_sum >= (c_ptr_w+1)'(N)) ? c_ptr_w'(w_sum - (c_ptr_w+1)'(N))
                                               : c_ptr_w'(w_sum);
            if (!w_found && bus.m_cyc[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
    end

    // Owner's cyc/stb, selected with constant indices per slot
    always_comb begin
        w_owner_cyc = 1'b0;
        w_owner_stb = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (r_owner == c_ptr_w'(i)) begin
                w_owner_cyc = bus.m_cyc[i];
                w_owner_stb = bus.m_stb[i];
            end
        end
    end

    // Next-state logic: grant in IDLE, release when owner drops cyc
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_owner_nxt = r_owner;
        w_grant_nxt = o_grant;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_state_nxt = OWNED;
                    w_owner_nxt = w_pick;
                    w_grant_nxt = N'(1) << w_pick;
                    w_ptr_nxt   = (w_pick == c_ptr_w'(N-1)) ? '0 : w_pick + 1'b1;
                end
            end
            OWNED: begin
                if (!w_owner_cyc) begin
                    w_state_nxt = IDLE;
                    w_grant_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    // State, pointer, owner and grant registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_owner <= '0;
            o_grant <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_owner <= w_owner_nxt;
            o_grant <= w_grant_nxt;
        end
    end

    assign o_busy = (r_state == OWNED);

`ifdef WB_ARB_TIMEOUT_EN
    logic [7:0] r_wd;
    logic       w_stall;

    // A stalled cycle is a strobed owner cycle without any slave response;
    // the count includes the current cycle so the error lands on stall #TIMEOUT
    assign w_stall   = (r_state == OWNED) && w_owner_stb && !bus.s_ack && !bus.s_err;
    assign w_timeout = w_stall && (({1'b0, r_wd} + 9'd1) == 9'(TIMEOUT));

    // Watchdog counter, cleared whenever the stall run is broken or fires
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wd <= '0;
        end else if (!w_stall || w_timeout) begin
            r_wd <= '0;
        end else begin
            r_wd <= r_wd + 8'd1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // Bus routing: owner's signals to the slave, responses back to owner only
    always_comb begin
        bus.s_cyc     = 1'b0;
        bus.s_stb     = 1'b0;
        bus.s_we      = 1'b0;
        bus.s_adr     = '0;
        bus.s_o_dat   = '0;
        bus.s_sel     = '0;
        bus.s_4_burst = 1'b0;
        bus.s_8_burst = 1'b0;
        bus.m_ack     = '0;
        bus.m_err     = '0;
        bus.m_i_dat   = '0;
        if (r_state == OWNED) begin
            bus.m_i_dat = bus.s_i_dat;
            for (int i = 0; i < N; i++) begin
                if (r_owner == c_ptr_w'(i)) begin
                    bus.s_cyc     = bus.m_cyc[i];
                    bus.s_stb     = bus.m_stb[i] && !w_timeout;
                    bus.s_we      = bus.m_we[i];
                    bus.s_adr     = bus.m_adr[i*ADDR_W +: ADDR_W];
                    bus.s_o_dat   = bus.m_o_dat[i*DATA_W +: DATA_W];
                    bus.s_sel     = bus.m_sel[i*SEL_W +: SEL_W];
                    bus.s_4_burst = bus.m_4_burst[i];
                    bus.s_8_burst = bus.m_8_burst[i];
                    bus.m_ack[i]  = bus.s_ack;
                    bus.m_err[i]  = bus.s_err || w_timeout;
                end
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_wb_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_rr_arbiter
//  Brief    : Directed self-checking bench for wb_rr_arbiter (N=3).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_wb_rr_arbiter;
    localparam int N       = 3;
    localparam int ADDR_W  = 24;
    localparam int DATA_W  = 16;
    localparam int SEL_W   = 2;
    localparam int TIMEOUT = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] grant;
    logic         busy;
    int           n_cmp = 0;
    int           n_bad = 0;

    always #5 clk = ~clk;

    wb_rr_arbiter_if #(.N(N), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SEL_W(SEL_W)) bus ();

    wb_rr_arbiter #(
        .N(N), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SEL_W(SEL_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .bus     (bus),
        .o_grant (grant),
        .o_busy  (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next falling edge
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    logic [N-1:0] exp_rr [4];
    logic         any_err;

    initial begin
        exp_rr = '{3'b001, 3'b010, 3'b100, 3'b001};
        rst           = 1'b1;
        bus.m_cyc     = '0;
        bus.m_stb     = '0;
        bus.m_we      = '0;
        bus.m_adr     = '0;
        bus.m_o_dat   = '0;
        bus.m_sel     = '0;
        bus.m_4_burst = '0;
        bus.m_8_burst = '0;
        bus.s_ack     = 1'b0;
        bus.s_err     = 1'b0;
        bus.s_i_dat   = 16'hBEEF;
        tick();
        tick();

        // Reset state
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_s_cyc", 32'(bus.s_cyc), 32'h0);
        check("rst_m_i_dat", 32'(bus.m_i_dat), 32'h0);
        rst = 1'b0;

        // Single request from master 1, acked on its second owned cycle
        bus.m_cyc[1] = 1'b1;
        bus.m_stb[1] = 1'b1;
        bus.m_sel[2 +: 2] = 2'b11;
        bus.m_adr[ADDR_W +: ADDR_W] = 24'h001010;
        #1;
        check("single_idle_cyc", 32'(bus.s_cyc), 32'h0);
        tick();
        check("single_s_cyc", 32'(bus.s_cyc), 32'h1);
        check("single_grant", 32'(grant), 32'h2);
        check("single_busy", 32'(busy), 32'h1);
        check("single_adr", 32'(bus.s_adr), 32'h001010);
        check("single_sel", 32'(bus.s_sel), 32'h3);
        check("single_wait_ack", 32'(bus.m_ack), 32'h0);
        tick();
        bus.s_ack = 1'b1;
        #1;
        check("single_ack", 32'(bus.m_ack), 32'h2);
        check("single_rdata", 32'(bus.m_i_dat), 32'hBEEF);
        check("single_err", 32'(bus.m_err), 32'h0);
        tick();
        bus.s_ack    = 1'b0;
        bus.m_cyc[1] = 1'b0;
        bus.m_stb[1] = 1'b0;
        #1;
        check("single_ack_pulse", 32'(bus.m_ack), 32'h0);
        check("single_release_cyc", 32'(bus.s_cyc), 32'h0);
        tick();
        check("single_idle_grant", 32'(grant), 32'h0);
        check("single_idle_busy", 32'(busy), 32'h0);
        check("single_idle_rdata", 32'(bus.m_i_dat), 32'h0);

        // Round robin from pointer 0, all masters re-requesting
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.m_cyc = 3'b111;
        bus.m_stb = 3'b111;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rr_grant", 32'(grant), 32'(exp_rr[i]));
            bus.s_ack = 1'b1;
            #1;
            check("rr_ack", 32'(bus.m_ack), 32'(exp_rr[i]));
            tick();
            bus.s_ack = 1'b0;
            bus.m_cyc = bus.m_cyc & ~exp_rr[i];
            bus.m_stb = bus.m_stb & ~exp_rr[i];
            #1;
            check("rr_gap_cyc", 32'(bus.s_cyc), 32'h0);
            tick();
            check("rr_idle_grant", 32'(grant), 32'h0);
            bus.m_cyc = bus.m_cyc | exp_rr[i];
            bus.m_stb = bus.m_stb | exp_rr[i];
        end
        bus.m_cyc = '0;
        bus.m_stb = '0;
        tick();
        tick();

        // Burst lock: master 0 runs 8 beats with stb gaps while master 2 waits
        bus.m_cyc[0]     = 1'b1;
        bus.m_stb[0]     = 1'b1;
        bus.m_8_burst[0] = 1'b1;
        tick();
        check("burst_grant", 32'(grant), 32'h1);
        check("burst_hint8", 32'(bus.s_8_burst), 32'h1);
        check("burst_hint4", 32'(bus.s_4_burst), 32'h0);
        bus.m_cyc[2] = 1'b1;
        bus.m_stb[2] = 1'b1;
        for (int b = 0; b < 8; b++) begin
            if (b % 2 == 1) begin
                bus.m_stb[0] = 1'b0;
                #1;
                check("burst_gap_stb", 32'(bus.s_stb), 32'h0);
                tick();
                check("burst_gap_hold", 32'(grant), 32'h1);
                bus.m_stb[0] = 1'b1;
            end
            bus.s_ack = 1'b1;
            #1;
            check("burst_ack", 32'(bus.m_ack), 32'h1);
            tick();
            bus.s_ack = 1'b0;
        end
        bus.m_cyc[0]     = 1'b0;
        bus.m_stb[0]     = 1'b0;
        bus.m_8_burst[0] = 1'b0;
        #1;
        check("burst_release_cyc", 32'(bus.s_cyc), 32'h0);
        tick();
        check("burst_idle_grant", 32'(grant), 32'h0);
        tick();
        check("burst_next_grant", 32'(grant), 32'h4);

        // ack and err together are both forwarded to the owner only
        bus.s_ack = 1'b1;
        bus.s_err = 1'b1;
        #1;
        check("ackerr_ack", 32'(bus.m_ack), 32'h4);
        check("ackerr_err", 32'(bus.m_err), 32'h4);
        tick();
        bus.s_ack = 1'b0;
        bus.s_err = 1'b0;

        // Master 1 requests during master 2's ownership, withdraws in IDLE
        bus.m_cyc[1] = 1'b1;
        bus.m_cyc[2] = 1'b0;
        bus.m_stb[2] = 1'b0;
        tick();
        bus.m_cyc[1] = 1'b0;
        tick();
        check("withdraw_grant", 32'(grant), 32'h0);
        check("withdraw_busy", 32'(busy), 32'h0);

        // Mid-transaction asynchronous reset
        bus.m_cyc[0] = 1'b1;
        bus.m_stb[0] = 1'b1;
        tick();
        check("midrst_pre_grant", 32'(grant), 32'h1);
        bus.s_ack = 1'b1;
        #1;
        check("midrst_pre_ack", 32'(bus.m_ack), 32'h1);
        rst = 1'b1;
        #1;
        check("midrst_s_cyc", 32'(bus.s_cyc), 32'h0);
        check("midrst_s_stb", 32'(bus.s_stb), 32'h0);
        check("midrst_grant", 32'(grant), 32'h0);
        check("midrst_ack", 32'(bus.m_ack), 32'h0);
        check("midrst_err", 32'(bus.m_err), 32'h0);
        bus.s_ack    = 1'b0;
        bus.m_cyc[2] = 1'b1;
        bus.m_stb[2] = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        check("midrst_ptr_zero", 32'(grant), 32'h1);
        bus.m_cyc = '0;
        bus.m_stb = '0;
        tick();
        tick();

        // Stalled owner: master 1 strobes with no slave response
        bus.m_cyc[1] = 1'b1;
        bus.m_stb[1] = 1'b1;
        tick();
        check("stall_grant", 32'(grant), 32'h2);
`ifdef WB_ARB_TIMEOUT_EN
        for (int c = 1; c <= 5; c++) begin
            check("wd_err", 32'(bus.m_err), (c == 4) ? 32'h2 : 32'h0);
            check("wd_stb", 32'(bus.s_stb), (c == 4) ? 32'h0 : 32'h1);
            tick();
        end
        check("wd_hold_grant", 32'(grant), 32'h2);
`else
        any_err = 1'b0;
        for (int c = 0; c < 300; c++) begin
            any_err = any_err | (bus.m_err != '0);
            tick();
        end
        check("stall_no_err", 32'(any_err), 32'h0);
        check("stall_stb", 32'(bus.s_stb), 32'h1);
        check("stall_hold_grant", 32'(grant), 32'h2);
`endif
        bus.m_cyc = '0;
        bus.m_stb = '0;
        tick();
        tick();
        check("end_idle_busy", 32'(busy), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
